// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared types and codes for the multi-cycle RV32 subset control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode constants, immediate-format, ALU source and ALU op codes,
//           and the opcode-class struct produced by the decoder.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Immediate format select, consumed by the shared immediate generator.
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
   localparam logic [1:0] ALU_SRC_A_RS1   = 2'b01;
   localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b10;

   localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // One-hot instruction class; all zero means the opcode is not supported.
   typedef struct packed {
      logic is_r;
      logic is_i;
      logic is_lw;
      logic is_sw;
      logic is_beq;
   } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purpose: opcode-to-instruction-class decoder with illegal-opcode indication.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows opcode_i.
// Ports: opcode_i (IR[6:0]) in; op_class_o (one-hot class) out; illegal_o (no class matched) out.
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   output op_class_t  op_class_o,
   output logic       illegal_o
);

   always_comb begin
      op_class_o = '0;
      case (opcode_i)
         OP_R:    op_class_o.is_r   = 1'b1;
         OP_I:    op_class_o.is_i   = 1'b1;
         OP_LW:   op_class_o.is_lw  = 1'b1;
         OP_SW:   op_class_o.is_sw  = 1'b1;
         OP_BEQ:  op_class_o.is_beq = 1'b1;
         default: op_class_o = '0;
      endcase
   end

   assign illegal_o = ~(|op_class_o);

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) for the RV32 subset core.
// Latency: R/I 4, beq 3, sw 4, lw 5 cycles with zero-wait memory; each memory wait adds 1.
// Backpressure: FETCH and MEM hold until mem_ready_i pulses; start_i only sampled at boundaries.
// Ports: clk_i/rst_i clock and async high reset; start_i run enable; opcode_i IR[6:0];
//        zero_i ALU zero; mem_ready_i memory ack; mem_*/iord/ir_write/pc_* memory and PC
//        control; imm_sel/alu_src_a/alu_src_b/alu_op datapath selects; reg_write/mem_to_reg
//        writeback control; retired_o retire count; illegal_o sticky flag; state_o debug state.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int RET_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             iord_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             pc_src_o,
   output logic [1:0]       imm_sel_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_write_o,
   output logic             mem_to_reg_o,
   output logic [RET_W-1:0] retired_o,
   output logic             illegal_o,
   output logic [2:0]       state_o
);

   state_t           state_q, state_d;
   op_class_t        op_class;
   logic             dec_illegal;
   logic             retire;
   logic             illegal_set;
   logic [RET_W-1:0] retired_q;
   logic             illegal_q;
   state_t           boundary_state;

   multicycle_ctrl_decode u_decode (
      .opcode_i   (opcode_i),
      .op_class_o (op_class),
      .illegal_o  (dec_illegal)
   );

   // Where an instruction goes once it retires.
   assign boundary_state = start_i ? ST_FETCH : ST_IDLE;

   always_comb begin
      state_d      = state_q;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 1'b0;
      imm_sel_o    = IMM_I;
      alu_src_a_o  = ALU_SRC_A_PC;
      alu_src_b_o  = ALU_SRC_B_RS2;
      alu_op_o     = ALU_OP_ADD;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      retire       = 1'b0;
      illegal_set  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_FETCH;
         end

         ST_FETCH: begin
            // ALU computes PC + 4 every FETCH cycle; it is only committed on the ack.
            mem_req_o   = 1'b1;
            iord_o      = 1'b0;
            alu_src_a_o = ALU_SRC_A_PC;
            alu_src_b_o = ALU_SRC_B_FOUR;
            alu_op_o    = ALU_OP_ADD;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               pc_src_o   = 1'b0;
               state_d    = ST_DECODE;
            end
         end

         ST_DECODE: begin
            // Speculatively form the branch target OldPC + immB into ALUOut.
            alu_src_a_o = ALU_SRC_A_OLDPC;
            alu_src_b_o = ALU_SRC_B_IMM;
            imm_sel_o   = IMM_B;
            alu_op_o    = ALU_OP_ADD;
            if (dec_illegal) begin
               illegal_set = 1'b1;
               state_d     = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            alu_src_a_o = ALU_SRC_A_RS1;
            if (op_class.is_r) begin
               alu_src_b_o = ALU_SRC_B_RS2;
               alu_op_o    = ALU_OP_FUNCT;
               state_d     = ST_WB;
            end else if (op_class.is_i) begin
               alu_src_b_o = ALU_SRC_B_IMM;
               imm_sel_o   = IMM_I;
               alu_op_o    = ALU_OP_FUNCT;
               state_d     = ST_WB;
            end else if (op_class.is_lw || op_class.is_sw) begin
               alu_src_b_o = ALU_SRC_B_IMM;
               imm_sel_o   = op_class.is_sw ? IMM_S : IMM_I;
               alu_op_o    = ALU_OP_ADD;
               state_d     = ST_MEM;
            end else if (op_class.is_beq) begin
               // Compare rs1 - rs2; take the target held in ALUOut when equal.
               alu_src_b_o = ALU_SRC_B_RS2;
               alu_op_o    = ALU_OP_SUB;
               pc_src_o    = 1'b1;
               pc_write_o  = zero_i;
               retire      = 1'b1;
               state_d     = boundary_state;
            end else begin
               // IR is stable from DECODE, so this only guards against an opcode change.
               alu_src_a_o = ALU_SRC_A_PC;
               illegal_set = 1'b1;
               state_d     = ST_HALT;
            end
         end

         ST_MEM: begin
            mem_req_o = 1'b1;
            iord_o    = 1'b1;
            mem_we_o  = op_class.is_sw;
            if (mem_ready_i) begin
               if (op_class.is_sw) begin
                  retire  = 1'b1;
                  state_d = boundary_state;
               end else begin
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = op_class.is_lw;
            retire       = 1'b1;
            state_d      = boundary_state;
         end

         ST_HALT: state_d = ST_HALT;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + RET_W'(1);
         if (illegal_set) illegal_q <= 1'b1;
      end
   end

   assign retired_o = retired_q;
   assign illegal_o = illegal_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: self-checking bench for multicycle_ctrl with randomized instruction mix.
// Latency: n/a.
// Backpressure: randomized memory wait states in FETCH and MEM.
module tb_multicycle_ctrl;

   localparam int RW  = 4;
   localparam int MOD = 16;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_HALT = 6;
   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [6:0]    opcode_i;
   logic          zero_i;
   logic          mem_ready_i;
   logic          mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o;
   logic [1:0]    imm_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o;
   logic          reg_write_o, mem_to_reg_o;
   logic [RW-1:0] retired_o;
   logic          illegal_o;
   logic [2:0]    state_o;

   int tests = 0;
   int fails = 0;
   int model_ret = 0;

   multicycle_ctrl #(.RET_W(RW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .opcode_i     (opcode_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .iord_o       (iord_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .pc_src_o     (pc_src_o),
      .imm_sel_o    (imm_sel_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .reg_write_o  (reg_write_o),
      .mem_to_reg_o (mem_to_reg_o),
      .retired_o    (retired_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      tests++;
      assert (obs === req) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, req, $time);
      end
   endtask

   function automatic logic [6:0] op_of(input int cls);
      case (cls)
         C_R:     return 7'b0110011;
         C_I:     return 7'b0010011;
         C_LW:    return 7'b0000011;
         C_SW:    return 7'b0100011;
         default: return 7'b1100011;
      endcase
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      for (int c = 0; c < 5; c++) if (op == op_of(c)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] obs_vec();
      return {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
              imm_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, mem_to_reg_o};
   endfunction

   // Expected control outputs for one cycle, straight from the per-phase control table.
   function automatic logic [15:0] exp_vec(input int stg, input int cls, input bit rdy, input bit zero);
      logic mreq, mwe, iord, irw, pcw, pcs, rw, m2r;
      logic [1:0] imm, a, b, op;
      {mreq, mwe, iord, irw, pcw, pcs, rw, m2r} = '0;
      {imm, a, b, op} = '0;
      case (stg)
         S_FETCH:  begin mreq = 1; b = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE: begin a = 2'b10; b = 2'b10; imm = 2'b10; end
         S_EXEC: begin
            a = 2'b01;
            case (cls)
               C_R:  begin b = 2'b00; op = 2'b10; end
               C_I:  begin b = 2'b10; imm = 2'b00; op = 2'b10; end
               C_LW: begin b = 2'b10; imm = 2'b00; op = 2'b00; end
               C_SW: begin b = 2'b10; imm = 2'b01; op = 2'b00; end
               default: begin b = 2'b00; op = 2'b01; pcs = 1; pcw = zero; end
            endcase
         end
         S_MEM:    begin mreq = 1; iord = 1; mwe = (cls == C_SW); end
         S_WB:     begin rw = 1; m2r = (cls == C_LW); end
         default:  ;
      endcase
      return {mreq, mwe, iord, irw, pcw, pcs, imm, a, b, op, rw, m2r};
   endfunction

   // Entered at posedge+1 in IDLE; leaves at posedge+1 in FETCH.
   task automatic go_idle(input int idle_cycles);
      for (int k = 0; k <= idle_cycles; k++) begin
         start_i     = (k == idle_cycles);
         mem_ready_i = 1'($urandom);
         opcode_i    = 7'($urandom);
         zero_i      = 1'($urandom);
         @(negedge clk_i);
         chk("idle_state", 32'(state_o), S_IDLE);
         chk("idle_strobes", 32'(obs_vec()), 0);
         @(posedge clk_i); #1;
      end
   endtask

   // Runs one legal instruction from its first FETCH cycle through retirement.
   task automatic run_instr(input int cls, input int wf, input int wm, input bit zero, input bit cont);
      int stg[$];
      bit rdy[$];
      int n;
      for (int j = 0; j <= wf; j++) begin stg.push_back(S_FETCH); rdy.push_back(j == wf); end
      stg.push_back(S_DECODE); rdy.push_back(1'b0);
      stg.push_back(S_EXEC);   rdy.push_back(1'b0);
      if (cls == C_LW || cls == C_SW)
         for (int j = 0; j <= wm; j++) begin stg.push_back(S_MEM); rdy.push_back(j == wm); end
      if (cls == C_R || cls == C_I || cls == C_LW) begin stg.push_back(S_WB); rdy.push_back(1'b0); end
      n = stg.size();
      for (int k = 0; k < n; k++) begin
         opcode_i    = (stg[k] == S_FETCH) ? 7'($urandom) : op_of(cls);
         mem_ready_i = (stg[k] == S_FETCH || stg[k] == S_MEM) ? rdy[k] : 1'($urandom);
         zero_i      = (stg[k] == S_EXEC) ? zero : 1'($urandom);
         start_i     = (k == n - 1) ? cont : 1'($urandom);
         @(negedge clk_i);
         chk("state", 32'(state_o), 32'(stg[k]));
         chk("strobes", 32'(obs_vec()), 32'(exp_vec(stg[k], cls, rdy[k], zero)));
         chk("retired", 32'(retired_o), 32'(model_ret));
         chk("illegal_clear", 32'(illegal_o), 0);
         @(posedge clk_i); #1;
      end
      model_ret = (model_ret + 1) % MOD;
      chk("boundary_state", 32'(state_o), cont ? S_FETCH : S_IDLE);
      chk("retired_after", 32'(retired_o), 32'(model_ret));
   endtask

   initial begin
      int cls, wf, wm;
      bit cont;
      logic [6:0] bad;

      rst_i = 1'b1; start_i = 1'b0; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), S_IDLE);
      chk("rst_strobes", 32'(obs_vec()), 0);
      chk("rst_retired", 32'(retired_o), 0);
      chk("rst_illegal", 32'(illegal_o), 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      go_idle(2);

      // Directed: R zero-wait, lw with waits, sw, beq taken and not taken.
      run_instr(C_R, 0, 0, 1'b0, 1'b1);
      run_instr(C_LW, 2, 2, 1'b0, 1'b1);
      run_instr(C_SW, 0, 0, 1'b0, 1'b1);
      run_instr(C_BEQ, 0, 0, 1'b1, 1'b1);
      run_instr(C_BEQ, 0, 0, 1'b0, 1'b0);
      go_idle(1);

      // Randomized instruction mix, wait states and run-enable drops.
      for (int i = 0; i < 40; i++) begin
         cls  = $urandom_range(0, 4);
         wf   = $urandom_range(0, 2);
         wm   = $urandom_range(0, 2);
         cont = ($urandom_range(0, 3) != 0);
         run_instr(cls, wf, wm, 1'($urandom), cont);
         if (!cont) go_idle($urandom_range(0, 2));
      end

      // Illegal opcode: FETCH, DECODE, then absorbing HALT.
      do bad = 7'($urandom); while (is_legal(bad));
      wf = $urandom_range(0, 2);
      for (int k = 0; k <= wf + 1; k++) begin
         opcode_i    = (k <= wf) ? 7'($urandom) : bad;
         mem_ready_i = (k <= wf) ? (k == wf) : 1'($urandom);
         start_i     = 1'($urandom);
         zero_i      = 1'($urandom);
         @(negedge clk_i);
         chk("ill_pre_state", 32'(state_o), (k <= wf) ? S_FETCH : S_DECODE);
         chk("ill_pre_strobes", 32'(obs_vec()),
             32'(exp_vec((k <= wf) ? S_FETCH : S_DECODE, C_R, k == wf, 1'b0)));
         chk("ill_pre_flag", 32'(illegal_o), 0);
         @(posedge clk_i); #1;
      end
      for (int k = 0; k < 20; k++) begin
         opcode_i    = 7'($urandom);
         mem_ready_i = 1'($urandom);
         start_i     = 1'($urandom);
         zero_i      = 1'($urandom);
         @(negedge clk_i);
         chk("halt_state", 32'(state_o), S_HALT);
         chk("halt_strobes", 32'(obs_vec()), 0);
         chk("halt_illegal", 32'(illegal_o), 1);
         chk("halt_retired", 32'(retired_o), 32'(model_ret));
         @(posedge clk_i); #1;
      end

      // Reset out of HALT clears flag and counter.
      rst_i = 1'b1;
      #1;
      chk("halt_rst_state", 32'(state_o), S_IDLE);
      chk("halt_rst_illegal", 32'(illegal_o), 0);
      chk("halt_rst_retired", 32'(retired_o), 0);
      model_ret = 0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      go_idle(1);

      // Counter wrap: fill to all-ones then retire once more.
      for (int i = 0; i < MOD - 1; i++) run_instr($urandom_range(0, 4), 0, 0, 1'($urandom), 1'b1);
      chk("ret_all_ones", 32'(retired_o), MOD - 1);
      run_instr(C_R, 0, 0, 1'b0, 1'b1);
      chk("ret_wrap", 32'(retired_o), 0);

      // Asynchronous reset while FETCH is requesting memory.
      mem_ready_i = 1'b0;
      start_i     = 1'b1;
      run_instr(C_I, 0, 0, 1'b0, 1'b1);
      mem_ready_i = 1'b0;
      #1;
      chk("fetch_req_before_rst", 32'(mem_req_o), 1);
      rst_i = 1'b1;
      #1;
      chk("fetch_req_drop", 32'(mem_req_o), 0);
      chk("fetch_rst_state", 32'(state_o), S_IDLE);
      model_ret = 0;
      @(posedge clk_i); #1;
      rst_i   = 1'b0;
      start_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_state", 32'(state_o), S_IDLE);
      chk("post_rst_retired", 32'(retired_o), 0);
      chk("post_rst_illegal", 32'(illegal_o), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the RV32 subset core: R-type, I-type ALU, lw, sw and beq.
- Sequences one shared memory port, the register file, the ALU and the immediate generator across FETCH/DECODE/EXEC/MEM/WB.
- Drives the immediate-format select so a single extender serves I, S and B formats.
- Also keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- RET_W, 32, width of retired-instruction counter (wraps modulo 2^RET_W).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  run enable; sampled in IDLE and at each instruction boundary.
- opcode_i  in  7  IR[6:0]; valid from DECODE onward.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory ack; one-cycle pulse completes the current request.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write (sw only).
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  IR load strobe; datapath also loads OldPC <= PC.
- pc_write_o  out  1  PC load strobe.
- pc_src_o  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- imm_sel_o  out  2  immediate format: 00 = I, 01 = S, 10 = B.
- alu_src_a_o  out  2  ALU A: 00 = PC, 01 = rs1, 10 = OldPC.
- alu_src_b_o  out  2  ALU B: 00 = rs2, 01 = const 4, 10 = imm.
- alu_op_o  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- reg_write_o  out  1  register-file write strobe.
- mem_to_reg_o  out  1  writeback select: 1 = memory data, 0 = ALUOut.
- retired_o  out  RET_W  retired-instruction count.
- illegal_o  out  1  sticky illegal-opcode flag.
- state_o  out  3  current state, for debug.

Behaviour:
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6.
- Reset (async) puts state in IDLE and clears retired_o and illegal_o.
- All strobes are combinational from state, opcode_i, zero_i and mem_ready_i.
- Every strobe is 0 in IDLE, HALT and reset, and every strobe defaults to 0 unless listed below.
- IDLE: start_i = 1 -> FETCH next cycle.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 00, alu_src_b = 01, alu_op = 00.
  - Stays in FETCH while mem_ready_i = 0.
  - In the mem_ready_i cycle: ir_write = 1, pc_write = 1, pc_src = 0 (PC <= PC + 4), then -> DECODE.
- DECODE: alu_src_a = 10, alu_src_b = 10, imm_sel = 10, alu_op = 00, so ALUOut <= branch target.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011} -> HALT, illegal_o <= 1.
  - Otherwise -> EXEC.
- EXEC by opcode:
  - R-type: a = 01, b = 00, alu_op = 10 -> WB.
  - I-type: a = 01, b = 10, imm_sel = 00, alu_op = 10 -> WB.
  - lw: a = 01, b = 10, imm_sel = 00, alu_op = 00 -> MEM.
  - sw: same as lw but imm_sel = 01 -> MEM.
  - beq: a = 01, b = 00, alu_op = 01; pc_src = 1 and pc_write = zero_i; instruction retires; -> boundary.
- MEM: mem_req = 1, iord = 1, mem_we = (opcode == sw).
  - Holds while mem_ready_i = 0.
  - On ready: sw retires -> boundary; lw -> WB.
- WB: reg_write = 1, mem_to_reg = (opcode == lw); instruction retires; -> boundary.
- Boundary: next state is FETCH if start_i = 1, else IDLE.
- Retire: retired_o increments by 1 on the clock edge leaving EXEC (beq), MEM (sw) or WB; wraps from all-ones to 0.
- HALT is absorbing; only rst_i exits it. mem_req_o stays 0 in HALT.
- Latencies in cycles with zero-wait memory:
  - R-type, I-type: 4.
  - beq, sw: 3 and 4.
  - lw: 5.
  - Each wait cycle adds 1.
- mem_ready_i outside FETCH/MEM is ignored.
- Reset asserted mid-request drops mem_req_o in the same cycle (async).
- start_i deasserted mid-instruction has no effect until the boundary.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BEQ;
  - IMM_I/IMM_S/IMM_B codes;
  - ALU_SRC_A/B codes;
  - ALU_OP codes.
- The immediate generator consumes imm_sel_o from this package.
- One natural sub-module: multicycle_ctrl_decode, a combinational opcode-to-class decoder that also produces the illegal indication. The FSM and counter stay in the top.

Test Plan:
- Reset mid-FETCH with mem_req = 1 -> mem_req_o falls immediately; after release: state_o = 0, retired_o = 0, illegal_o = 0.
- start_i = 1, zero-wait memory, opcode 0110011 -> states 1,2,3,5,1; reg_write_o = 1 only in WB; retired_o = 1 after 4 cycles.
- lw (0000011) with 2 wait cycles in both FETCH and MEM -> lw completes in 9 cycles; in MEM iord_o = 1, mem_we_o = 0; in WB mem_to_reg_o = 1.
- sw (0100011) -> EXEC shows imm_sel_o = 01; MEM shows mem_we_o = 1; returns to FETCH, never visits WB; retired_o += 1.
- beq with zero_i = 1 then with zero_i = 0 -> EXEC pc_write_o = 1, pc_src_o = 1 in the first case; pc_write_o = 0 in the second; both retire in 3 cycles.
- Opcode 1111111 -> HALT after DECODE, illegal_o = 1, no strobes for 20 cycles, retired_o unchanged; preset retired_o to all-ones and retire once -> wraps to 0.
